io_led_switch: RTL and testbench

//  Memory-mapped LED/switch peripheral downstream of MemOrIO; consumes its LEDCtrl/SwitchCtrl

---
 rtl/io_led_switch.sv | 138 +++++++++++++
 tb/tb_io_led_switch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_led_switch.sv
// Memory-mapped LED/switch peripheral: byte-lane LED register, switch synchroniser,
// shared-counter debounce FSM and a read-to-clear change flag.
module io_led_switch #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        LEDCtrl,
  input  logic        SwitchCtrl,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic [1:0]  addr_low,
  input  logic [15:0] write_data,
  input  logic [15:0] switch_i,
  output logic [15:0] io_rdata,
  output logic [15:0] led
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   led_q, led_d;
  logic [DATA_W-1:0]   sync1_q, sync2_q;
  logic [DATA_W-1:0]   stable_q, stable_d;
  logic [DATA_W-1:0]   snap_q, snap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flag_q, flag_d;
  logic                commit_c;
  logic                led_wr_c;
  logic                status_rd_c;

  assign led_wr_c    = LEDCtrl & ioWrite;
  assign status_rd_c = SwitchCtrl & ioRead & (addr_low == 2'd3);

  // State register; synchronous reset wins over every other update
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      led_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      snap_q   <= '0;
      cnt_q    <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      sync1_q  <= switch_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      snap_q   <= snap_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
    end
  end

  // Debounce FSM: any change of the synchronised word restarts the shared counter
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    snap_d   = snap_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q != stable_q) begin
          snap_d  = sync2_q;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (sync2_q == stable_q) begin
          state_d = IDLE;
        end else if (sync2_q != snap_q) begin
          snap_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
          stable_d = snap_q;
          commit_c = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Change flag: a commit in the same cycle as a status read keeps it set
  always_comb begin
    flag_d = flag_q;
    if (commit_c) begin
      flag_d = 1'b1;
    end else if (status_rd_c) begin
      flag_d = 1'b0;
    end
  end

  // LED register with byte-lane writes
  always_comb begin
    led_d = led_q;
    if (led_wr_c) begin
      case (addr_low)
        2'd0:    led_d = write_data;
        2'd1:    led_d[7:0]  = write_data[7:0];
        2'd2:    led_d[15:8] = write_data[7:0];
        default: led_d = led_q;
      endcase
    end
  end

  // Read mux; LED select takes priority over switch select
  always_comb begin
    io_rdata = '0;
    if (LEDCtrl && ioRead) begin
      io_rdata = led_q;
    end else if (SwitchCtrl && ioRead) begin
      case (addr_low)
        2'd0:    io_rdata = stable_q;
        2'd1:    io_rdata = {8'h00, stable_q[7:0]};
        2'd2:    io_rdata = {8'h00, stable_q[15:8]};
        default: io_rdata = {15'h0000, flag_q};
      endcase
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_io_led_switch.sv
// Scoreboard bench for io_led_switch with a short debounce window.
module tb_io_led_switch;

  localparam int unsigned DEB = 4;

  logic        clock;
  logic        reset;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic        ioWrite;
  logic        ioRead;
  logic [1:0]  addr_low;
  logic [15:0] write_data;
  logic [15:0] switch_i;
  logic [15:0] io_rdata;
  logic [15:0] led;

  typedef struct {
    string       name;
    bit          is_led;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  io_led_switch #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock      (clock),
    .reset      (reset),
    .LEDCtrl    (LEDCtrl),
    .SwitchCtrl (SwitchCtrl),
    .ioWrite    (ioWrite),
    .ioRead     (ioRead),
    .addr_low   (addr_low),
    .write_data (write_data),
    .switch_i   (switch_i),
    .io_rdata   (io_rdata),
    .led        (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: drains every expectation queued during the current cycle
  exp_t        e;
  logic [15:0] act;
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = e.is_led ? led : io_rdata;
      total++;
      if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic bus_idle();
    LEDCtrl = 1'b0; SwitchCtrl = 1'b0; ioWrite = 1'b0; ioRead = 1'b0;
    addr_low = 2'd0; write_data = 16'h0000;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    bus_idle();
  endtask

  task automatic exp_led(input string n, input logic [15:0] v);
    exp_q.push_back('{n, 1'b1, v});
  endtask

  task automatic exp_rd(input string n, input logic [15:0] v);
    exp_q.push_back('{n, 1'b0, v});
  endtask

  task automatic sw_read(input string n, input logic [1:0] a, input logic [15:0] v);
    SwitchCtrl = 1'b1; ioRead = 1'b1; addr_low = a;
    exp_rd(n, v);
  endtask

  task automatic led_write(input logic [1:0] a, input logic [15:0] d);
    LEDCtrl = 1'b1; ioWrite = 1'b1; addr_low = a; write_data = d;
  endtask

  // Status read that drops the strobe before the edge, so the flag is not cleared
  task automatic peek_status(input string n, input logic [15:0] v);
    sw_read(n, 2'd3, v);
    @(negedge clock);
    #1;
    bus_idle();
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    switch_i = 16'h0000;
    bus_idle();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    exp_led("rst_led", 16'h0000);
    sw_read("rst_sw", 2'd0, 16'h0000);
    step();
    peek_status("rst_flag", 16'h0000);
    step();

    // LED register and read mux
    led_write(2'd0, 16'hA5C3);
    exp_led("led_pre", 16'h0000);
    step();
    exp_led("led_w0", 16'hA5C3);
    led_write(2'd1, 16'h0011);
    step();
    exp_led("led_w1", 16'hA511);
    led_write(2'd2, 16'h00FF);
    step();
    exp_led("led_w2", 16'hFF11);
    led_write(2'd3, 16'h1234);
    step();
    exp_led("led_w3", 16'hFF11);
    LEDCtrl = 1'b1; ioRead = 1'b1; addr_low = 2'd0;
    exp_rd("led_rd", 16'hFF11);
    step();
    LEDCtrl = 1'b1; SwitchCtrl = 1'b1; ioRead = 1'b1; addr_low = 2'd2;
    exp_rd("led_prio", 16'hFF11);
    step();
    ioRead = 1'b1;
    exp_rd("no_sel", 16'h0000);
    step();
    SwitchCtrl = 1'b1; ioWrite = 1'b1; write_data = 16'hFFFF;
    step();
    exp_led("sw_wr_led", 16'hFF11);
    sw_read("sw_wr_sw", 2'd0, 16'h0000);
    step();

    // Bouncing input never commits
    for (int i = 0; i < 20; i++) begin
      switch_i = (((i / 2) % 2) == 0) ? 16'h0001 : 16'h0000;
      sw_read($sformatf("bounce_%0d", i), 2'd0, 16'h0000);
      step();
    end
    switch_i = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      sw_read($sformatf("bounce_tail_%0d", i), 2'd0, 16'h0000);
      step();
    end
    peek_status("bounce_flag", 16'h0000);
    step();

    // Clean change commits six edges after the sampling edge
    switch_i = 16'h8001;
    sw_read("deb_pre", 2'd0, 16'h0000);
    for (int j = 1; j <= 7; j++) begin
      step();
      sw_read($sformatf("deb_%0d", j), 2'd0, (j == 7) ? 16'h8001 : 16'h0000);
    end
    step();
    sw_read("deb_lo", 2'd1, 16'h0001);
    step();
    sw_read("deb_hi", 2'd2, 16'h0080);
    step();
    sw_read("deb_flag1", 2'd3, 16'h0001);
    step();
    sw_read("deb_flag0", 2'd3, 16'h0000);
    step();

    // Mid-count change restarts the window; only the final word commits
    switch_i = 16'h0001;
    for (int j = 1; j <= 11; j++) begin
      step();
      if (j == 3) switch_i = 16'h0003;
      sw_read($sformatf("restart_%0d", j), 2'd0, (j >= 10) ? 16'h0003 : 16'h8001);
    end
    step();
    sw_read("restart_flag1", 2'd3, 16'h0001);
    step();
    sw_read("restart_flag0", 2'd3, 16'h0000);
    step();

    // Status clear on the commit edge leaves the flag set
    switch_i = 16'h0100;
    for (int j = 1; j <= 5; j++) begin
      step();
      sw_read($sformatf("setwin_%0d", j), 2'd0, 16'h0003);
    end
    step();
    sw_read("setwin_pre", 2'd3, 16'h0000);
    step();
    peek_status("setwin_flag", 16'h0001);
    step();
    sw_read("setwin_sw", 2'd0, 16'h0100);
    step();

    // Reset during COUNT clears everything; held input is re-debounced
    switch_i = 16'h00F0;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_led("rst2_led", 16'h0000);
    sw_read("rst2_sw", 2'd0, 16'h0000);
    step();
    peek_status("rst2_flag", 16'h0000);
    for (int j = 7; j <= 12; j++) begin
      step();
      sw_read($sformatf("rst2_deb_%0d", j), 2'd0, (j == 12) ? 16'h00F0 : 16'h0000);
    end
    step();
    sw_read("rst2_flag1", 2'd3, 16'h0001);
    step();

    repeat (3) step();
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      step();
      guard++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
